seq_divider: RTL and testbench

Parametrised multi-cycle restoring divider that produces quotient and remainder from one combined double-width shift register, one iteration per clock. Generalises the team's fixed 32-bit remainder register into a complete self-sequencing block: it owns the FSM, the subtractor and the Start/Done handshake, and adds divide-by-zero handling. It also offers an optional signed mode. It sits beside the multiplier in the datapath's execute stage.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_rem_reg.sv | 46 ++++
 rtl/seq_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_divider.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding used by seq_divider.
package div_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_rem_reg.sv
// Double-width remainder/quotient register for seq_divider.
// Upper half holds the running remainder and lower half the dividend bits
// that are being shifted out while quotient bits are shifted in.
module div_rem_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   loadVal_i,
    input  logic               shift_i,
    input  logic               qBit_i,
    input  logic               hiWrite_i,
    input  logic [WIDTH-1:0]   hiVal_i,
    input  logic               fullWrite_i,
    input  logic [2*WIDTH-1:0] fullVal_i,
    output logic [2*WIDTH-1:0] r_o
);

    logic [2*WIDTH-1:0] r_q;
    logic [2*WIDTH-1:0] r_d;

    // Pick the next register value: load, full overwrite, or one shift step with optional upper-half replacement
    always_comb begin
        r_d = r_q;
        if (load_i) begin
            r_d = {{WIDTH{1'b0}}, loadVal_i};
        end else if (fullWrite_i) begin
            r_d = fullVal_i;
        end else if (shift_i) begin
            r_d = {(hiWrite_i ? hiVal_i : r_q[2*WIDTH-2:WIDTH-1]), r_q[WIDTH-2:0], qBit_i};
        end
    end

    // Register update with synchronous clear
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Start/Done handshake, divide-by-zero flag, WIDTH+2 cycles Start to Done.
// Optional two's-complement mode when the macro DIV_SIGNED_EN is defined,
// which also adds the Signed_op input.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
`ifdef DIV_SIGNED_EN
    input  logic             Signed_op,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_by_zero
);

    import div_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               negQ_q;
    logic               negR_q;
    logic               dz_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic               dbz_q;

    logic               signedMode;
    logic [WIDTH-1:0]   dividendMag;
    logic [WIDTH-1:0]   divisorMag;
    logic [2*WIDTH-1:0] r;
    logic [WIDTH:0]     shiftedHi;
    logic               remFits;
    logic [WIDTH-1:0]   remDiff;
    logic [WIDTH-1:0]   fixQuo;
    logic [WIDTH-1:0]   fixRem;
    logic               accept;
    logic               acceptZero;
    logic               loadCtl;
    logic               shiftCtl;
    logic               hiWriteCtl;
    logic               fullWriteCtl;
    logic [2*WIDTH-1:0] fullVal;

`ifdef DIV_SIGNED_EN
    assign signedMode = Signed_op;
`else
    assign signedMode = 1'b0;
`endif

    // Operand magnitudes, sign fix-up values and the trial subtraction for the current iteration
    always_comb begin
        dividendMag = (signedMode && Dividend[WIDTH-1]) ? -Dividend : Dividend;
        divisorMag  = (signedMode && Divisor[WIDTH-1])  ? -Divisor  : Divisor;
        // The shifted remainder needs one extra bit: the MSB that leaves the upper half on the shift.
        shiftedHi   = r[2*WIDTH-1:WIDTH-1];
        remFits     = (shiftedHi >= {1'b0, divisor_q});
        // When the subtraction fits, the result is below the divisor, so the extra top bit is always zero.
        remDiff     = shiftedHi[WIDTH-1:0] - divisor_q;
        fixQuo      = negQ_q ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        fixRem      = negR_q ? -r[2*WIDTH-1:WIDTH] : r[2*WIDTH-1:WIDTH];
    end

    // Datapath controls decoded from the current state and the start request
    always_comb begin
        accept       = (state_q == IDLE) && Start;
        acceptZero   = accept && (Divisor == '0);
        loadCtl      = accept && (Divisor != '0);
        shiftCtl     = (state_q == RUN);
        hiWriteCtl   = shiftCtl && remFits;
        fullWriteCtl = acceptZero || (state_q == FIX);
        fullVal      = acceptZero ? {Dividend, {WIDTH{1'b1}}} : {fixRem, fixQuo};
    end

    div_rem_reg #(
        .WIDTH(WIDTH)
    ) u_rem_reg (
        .clk         (clk),
        .Reset       (Reset),
        .load_i      (loadCtl),
        .loadVal_i   (dividendMag),
        .shift_i     (shiftCtl),
        .qBit_i      (remFits),
        .hiWrite_i   (hiWriteCtl),
        .hiVal_i     (remDiff),
        .fullWrite_i (fullWriteCtl),
        .fullVal_i   (fullVal),
        .r_o         (r)
    );

    // Controller FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (Divisor != '0) begin
                            cnt_q     <= CNT_W'(WIDTH);
                            divisor_q <= divisorMag;
                            negQ_q    <= signedMode && (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                            negR_q    <= signedMode && Dividend[WIDTH-1];
                            dz_q      <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            dz_q    <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    quo_q   <= r[WIDTH-1:0];
                    rem_q   <= r[2*WIDTH-1:WIDTH];
                    dbz_q   <= dz_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Quotient    = quo_q;
    assign Remainder   = rem_q;
    assign Div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 32-bit instance for the main
// directed cases and an 8-bit instance for back-to-back operation.
// Expected results are queued when a request is driven and compared when Done pulses.
module tb_seq_divider;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
        int          doneCyc;
    } expect_t;

    logic        clk;
    logic        Reset;
    int          cyc = 0;
    int          checkCount = 0;
    int          errorCount = 0;
    int          doneCount32 = 0;
    int          doneCount8 = 0;
    expect_t     sb32[$];
    expect_t     sb8[$];

    logic        Start;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
`ifdef DIV_SIGNED_EN
    logic        SignedOp;
`endif
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic        DivByZero;

    logic        Start8;
    logic [7:0]  Dividend8;
    logic [7:0]  Divisor8;
`ifdef DIV_SIGNED_EN
    logic        SignedOp8;
`endif
    logic        Busy8;
    logic        Done8;
    logic [7:0]  Quotient8;
    logic [7:0]  Remainder8;
    logic        DivByZero8;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Start       (Start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
`ifdef DIV_SIGNED_EN
        .Signed_op   (SignedOp),
`endif
        .Busy        (Busy),
        .Done        (Done),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_by_zero (DivByZero)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .Reset       (Reset),
        .Start       (Start8),
        .Dividend    (Dividend8),
        .Divisor     (Divisor8),
`ifdef DIV_SIGNED_EN
        .Signed_op   (SignedOp8),
`endif
        .Busy        (Busy8),
        .Done        (Done8),
        .Quotient    (Quotient8),
        .Remainder   (Remainder8),
        .Div_by_zero (DivByZero8)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One comparison: count it, and report tag/observed/expected on failure
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        assert (got === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result for a 32-bit request
    function automatic expect_t model32(input logic [31:0] a, input logic [31:0] b, input logic s, input int doneCyc);
        expect_t e;
        e.doneCyc = doneCyc;
        e.dz = 1'b0;
        if (b == 32'd0) begin
            e.quo = 32'hFFFF_FFFF;
            e.rem = a;
            e.dz  = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.quo = 32'h8000_0000;
            e.rem = 32'd0;
        end else if (s) begin
            e.quo = $signed(a) / $signed(b);
            e.rem = $signed(a) % $signed(b);
        end else begin
            e.quo = a / b;
            e.rem = a % b;
        end
        return e;
    endfunction

    // 32-bit scoreboard: pop and compare on every Done pulse
    always @(negedge clk) begin
        if (Done === 1'b1) begin
            expect_t e;
            doneCount32++;
            if (sb32.size() == 0) begin
                checkOutput("spurious_done32", {63'd0, Done}, 64'd0);
            end else begin
                e = sb32.pop_front();
                checkOutput("quo32", {32'd0, Quotient}, {32'd0, e.quo});
                checkOutput("rem32", {32'd0, Remainder}, {32'd0, e.rem});
                checkOutput("dbz32", {63'd0, DivByZero}, {63'd0, e.dz});
                checkOutput("busy_at_done32", {63'd0, Busy}, 64'd0);
                checkOutput("done_cycle32", 64'(cyc), 64'(e.doneCyc));
            end
        end
    end

    // 8-bit scoreboard
    always @(negedge clk) begin
        if (Done8 === 1'b1) begin
            expect_t e;
            doneCount8++;
            if (sb8.size() == 0) begin
                checkOutput("spurious_done8", {63'd0, Done8}, 64'd0);
            end else begin
                e = sb8.pop_front();
                checkOutput("quo8", {56'd0, Quotient8}, {32'd0, e.quo});
                checkOutput("rem8", {56'd0, Remainder8}, {32'd0, e.rem});
                checkOutput("dbz8", {63'd0, DivByZero8}, {63'd0, e.dz});
                checkOutput("done_cycle8", 64'(cyc), 64'(e.doneCyc));
            end
        end
    end

    // Drive one 32-bit request; when it should be accepted, queue its expected result
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input bit accept);
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
`ifdef DIV_SIGNED_EN
        SignedOp = s;
`endif
        Start = 1'b1;
        if (accept) sb32.push_back(model32(a, b, s, cyc + 1 + ((b == 32'd0) ? 1 : 34)));
        @(negedge clk);
        Start = 1'b0;
        if (accept) checkOutput((b == 32'd0) ? "busy_dz" : "busy_run", {63'd0, Busy}, (b == 32'd0) ? 64'd0 : 64'd1);
    endtask

    // Bounded wait for the 32-bit scoreboard to empty
    task automatic waitDrain32(input int maxCyc);
        for (int i = 0; i < maxCyc; i++) begin
            if (sb32.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain32_timeout", 64'(sb32.size()), 64'd0);
    endtask

    task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s);
        applyStimulus(a, b, s, 1'b1);
        waitDrain32(50);
    endtask

    int doneBefore;

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Dividend = '0;
        Divisor = '0;
        Start8 = 1'b0;
        Dividend8 = '0;
        Divisor8 = '0;
`ifdef DIV_SIGNED_EN
        SignedOp = 1'b0;
        SignedOp8 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {63'd0, Busy}, 64'd0);
        checkOutput("rst_done", {63'd0, Done}, 64'd0);
        checkOutput("rst_quo", {32'd0, Quotient}, 64'd0);
        checkOutput("rst_rem", {32'd0, Remainder}, 64'd0);
        checkOutput("rst_dbz", {63'd0, DivByZero}, 64'd0);
        Reset = 1'b0;

        $display("[TB] basic unsigned and divide by zero");
        runOp(32'd100, 32'd7, 1'b0);
        runOp(32'd5, 32'd0, 1'b0);

        $display("[TB] start during RUN is ignored");
        applyStimulus(32'd1000, 32'd3, 1'b0, 1'b1);
        doneBefore = doneCount32;
        repeat (8) @(negedge clk);
        Dividend = 32'd50;
        Divisor  = 32'd5;
        Start    = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        waitDrain32(50);
        repeat (5) @(negedge clk);
        checkOutput("ignore_one_done", 64'(doneCount32 - doneBefore), 64'd1);
        checkOutput("ignore_held_quo", {32'd0, Quotient}, 64'd333);

        $display("[TB] boundary operands");
        runOp(32'hFFFF_FFFF, 32'd1, 1'b0);
        runOp(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp(32'd7, 32'd100, 1'b0);
        runOp(32'h8000_0000, 32'd3, 1'b0);
        runOp(32'hFFFF_FFFE, 32'h8000_0001, 1'b0);
        runOp(32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runOp($urandom, 32'($urandom_range(1, 100000)), 1'b0);
        end

`ifdef DIV_SIGNED_EN
        $display("[TB] signed mode");
        runOp(32'hFFFF_FFF9, 32'd2, 1'b1);
        runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        runOp(32'd7, 32'hFFFF_FFFE, 1'b1);
        runOp(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        runOp(32'hFFFF_FFF9, 32'd0, 1'b1);
        runOp(32'hFFFF_FFF9, 32'd2, 1'b0);
`endif

        $display("[TB] 8-bit back-to-back");
        @(negedge clk);
        Dividend8 = 8'd255;
        Divisor8  = 8'd1;
        Start8    = 1'b1;
        sb8.push_back('{quo: 32'd255, rem: 32'd0, dz: 1'b0, doneCyc: cyc + 1 + 10});
        @(negedge clk);
        Start8 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (Done8 === 1'b1) break;
            @(negedge clk);
        end
        checkOutput("done8_seen", {63'd0, Done8}, 64'd1);
        Dividend8 = 8'd200;
        Divisor8  = 8'd7;
        Start8    = 1'b1;
        sb8.push_back('{quo: 32'd28, rem: 32'd4, dz: 1'b0, doneCyc: cyc + 1 + 10});
        @(negedge clk);
        Start8 = 1'b0;
        checkOutput("busy8_b2b", {63'd0, Busy8}, 64'd1);
        for (int i = 0; i < 30; i++) begin
            if (sb8.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain8_timeout", 64'(sb8.size()), 64'd0);
        checkOutput("done8_count", 64'(doneCount8), 64'd2);

        $display("[TB] reset during RUN");
        doneBefore = doneCount32;
        applyStimulus(32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", {63'd0, Busy}, 64'd0);
        checkOutput("midrst_done", {63'd0, Done}, 64'd0);
        checkOutput("midrst_quo", {32'd0, Quotient}, 64'd0);
        checkOutput("midrst_rem", {32'd0, Remainder}, 64'd0);
        checkOutput("midrst_dbz", {63'd0, DivByZero}, 64'd0);
        Reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("midrst_no_done", 64'(doneCount32 - doneBefore), 64'd0);
        runOp(32'd9, 32'd3, 1'b0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
